// File: rtl/msg_pkg.sv
// Shared constants, register map and bus-FSM state type for the message frame reader.
package msg_pkg;

  localparam logic [31:0] EXPECT_ID = 32'h1234EEE2;

  localparam int unsigned N_HDR = 11;
  localparam logic [31:0] HEADERS [N_HDR] = '{
    32'hAAAAAAAA, 32'hBBBBBBBB, 32'hCCCCCCCC, 32'h11111111,
    32'h22222222, 32'h33333333, 32'h44444444, 32'h55555555,
    32'h66666666, 32'h77777777, 32'h88888888
  };
  localparam logic [3:0] LAST_HDR = 4'd10;

  localparam logic [2:0] ADDR_STATUS = 3'd0;
  localparam logic [2:0] ADDR_MSG    = 3'd1;
  localparam logic [2:0] ADDR_ID     = 3'd2;
  localparam int unsigned FLUSH_BIT  = 4;

  typedef enum logic [3:0] {
    ID_REQ, ID_WAIT, POLL_REQ, POLL_WAIT, GAP, MSG_REQ, MSG_WAIT, FLUSH, HALT
  } state_t;

endpackage

// File: rtl/msg_word_parser.sv
// Frame-aligns the message word stream on its headers, fills shadow registers
// and commits a completed 31-word frame to the outputs in one cycle.
module msg_word_parser (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         word_valid,
  input  logic [31:0]  word,
  output logic         sync_hit,
  output logic [65:0]  box_min,
  output logic [65:0]  box_max,
  output logic [307:0] edges,
  output logic         frame_valid,
  output logic [15:0]  frame_count,
  output logic [7:0]   sync_err
);
  import msg_pkg::*;

  logic         in_frame;
  logic [1:0]   phase;
  logic [3:0]   hidx;
  logic [4:0]   didx;
  logic [65:0]  smin, smax;
  logic [307:0] sedge;
  logic         pad_ok, hdr_ok;

  // A mid-frame AAAAAAAA fails either the header or the pad check, so it needs no special case.
  always_comb begin
    pad_ok   = (word[31:27] == 5'd0) && (word[15:11] == 5'd0);
    hdr_ok   = (word == HEADERS[hidx]);
    sync_hit = word_valid && in_frame && ((phase == 2'd0) ? !hdr_ok : !pad_ok);
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      in_frame    <= 1'b0;
      phase       <= 2'd0;
      hidx        <= 4'd0;
      didx        <= 5'd0;
      smin        <= '0;
      smax        <= '0;
      sedge       <= '0;
      box_min     <= '0;
      box_max     <= '0;
      edges       <= '0;
      frame_valid <= 1'b0;
      frame_count <= '0;
      sync_err    <= '0;
    end else begin
      frame_valid <= 1'b0;
      if (sync_hit && sync_err != 8'hFF)
        sync_err <= sync_err + 8'd1;
      if (word_valid) begin
        if (!in_frame) begin
          if (word == HEADERS[0]) begin
            in_frame <= 1'b1;
            hidx     <= 4'd1;
            phase    <= 2'd1;
            didx     <= 5'd0;
          end
        end else if (phase == 2'd0) begin
          if (!hdr_ok) begin
            in_frame <= 1'b0;
          end else if (hidx == LAST_HDR) begin
            in_frame    <= 1'b0;
            box_min     <= smin;
            box_max     <= smax;
            edges       <= sedge;
            frame_valid <= 1'b1;
            frame_count <= frame_count + 16'd1;
          end else begin
            hidx  <= hidx + 4'd1;
            phase <= 2'd1;
          end
        end else if (!pad_ok) begin
          in_frame <= 1'b0;
        end else begin
          for (int unsigned k = 0; k < 6; k++) begin
            if (didx == 5'(k)) begin
              smin[k*11 +: 11] <= word[26:16];
              smax[k*11 +: 11] <= word[10:0];
            end
          end
          for (int unsigned k = 0; k < 14; k++) begin
            if (didx == 5'(k + 6)) begin
              sedge[(2*k)*11 +: 11]   <= word[26:16];
              sedge[(2*k+1)*11 +: 11] <= word[10:0];
            end
          end
          didx  <= didx + 5'd1;
          phase <= (phase == 2'd1) ? 2'd2 : 2'd0;
        end
      end
    end
  end

endmodule

// File: rtl/msg_frame_reader.sv
// Avalon-MM master that checks the processor ID, polls the message count and
// drains the message FIFO one word per REQ/WAIT pair into the frame parser.
module msg_frame_reader #(
  parameter int unsigned POLL_GAP  = 64,
  parameter logic [31:0] EXPECT_ID = msg_pkg::EXPECT_ID
) (
  input  logic         clk,
  input  logic         reset_n,
  output logic         m_chipselect,
  output logic         m_read,
  output logic         m_write,
  output logic [2:0]   m_address,
  output logic [31:0]  m_writedata,
  input  logic [31:0]  m_readdata,
  output logic [65:0]  box_min,
  output logic [65:0]  box_max,
  output logic [307:0] edges,
  output logic         frame_valid,
  output logic [15:0]  frame_count,
  output logic [7:0]   sync_err,
  output logic         id_error
);
  import msg_pkg::*;

  state_t      state, state_next;
  logic [7:0]  rem, rem_next;
  logic [15:0] gap_cnt, gap_next;
  logic        id_error_next;
  logic        word_valid;
  logic        sync_hit;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state    <= ID_REQ;
      rem      <= '0;
      gap_cnt  <= '0;
      id_error <= 1'b0;
    end else begin
      state    <= state_next;
      rem      <= rem_next;
      gap_cnt  <= gap_next;
      id_error <= id_error_next;
    end
  end

  always_comb begin
    state_next    = state;
    rem_next      = rem;
    gap_next      = gap_cnt;
    id_error_next = id_error;
    m_chipselect  = 1'b0;
    m_read        = 1'b0;
    m_write       = 1'b0;
    m_address     = ADDR_STATUS;
    m_writedata   = '0;
    word_valid    = 1'b0;
    case (state)
      ID_REQ: begin
        m_chipselect = 1'b1;
        m_read       = 1'b1;
        m_address    = ADDR_ID;
        state_next   = ID_WAIT;
      end
      ID_WAIT: begin
        if (m_readdata == EXPECT_ID) begin
          state_next = POLL_REQ;
        end else begin
          state_next    = HALT;
          id_error_next = 1'b1;
        end
      end
      POLL_REQ: begin
        m_chipselect = 1'b1;
        m_read       = 1'b1;
        m_address    = ADDR_STATUS;
        state_next   = POLL_WAIT;
      end
      POLL_WAIT: begin
        if (m_readdata[15:8] != 8'd0) begin
          rem_next   = m_readdata[15:8];
          state_next = MSG_REQ;
        end else begin
          gap_next   = '0;
          state_next = GAP;
        end
      end
      GAP: begin
        if (gap_cnt == 16'(POLL_GAP - 1))
          state_next = POLL_REQ;
        else
          gap_next = gap_cnt + 16'd1;
      end
      MSG_REQ: begin
        m_chipselect = 1'b1;
        m_read       = 1'b1;
        m_address    = ADDR_MSG;
        state_next   = MSG_WAIT;
      end
      MSG_WAIT: begin
        word_valid = 1'b1;
        rem_next   = rem - 8'd1;
        if (sync_hit)
          state_next = FLUSH;
        else if (rem == 8'd1)
          state_next = POLL_REQ;
        else
          state_next = MSG_REQ;
      end
      FLUSH: begin
        m_chipselect = 1'b1;
        m_write      = 1'b1;
        m_address    = ADDR_STATUS;
        m_writedata  = 32'd1 << FLUSH_BIT;
        state_next   = POLL_REQ;
      end
      HALT: state_next = HALT;
      default: state_next = ID_REQ;
    endcase
    // Strobes are gated by reset so the bus is quiet for the whole reset window.
    if (!reset_n) begin
      m_chipselect = 1'b0;
      m_read       = 1'b0;
      m_write      = 1'b0;
      m_address    = '0;
      m_writedata  = '0;
    end
  end

  msg_word_parser u_parser (
    .clk         (clk),
    .reset_n     (reset_n),
    .word_valid  (word_valid),
    .word        (m_readdata),
    .sync_hit    (sync_hit),
    .box_min     (box_min),
    .box_max     (box_max),
    .edges       (edges),
    .frame_valid (frame_valid),
    .frame_count (frame_count),
    .sync_err    (sync_err)
  );

endmodule

// File: tb/tb_msg_frame_reader.sv
// Directed bench for msg_frame_reader with a small Avalon slave model.
module tb_msg_frame_reader;

  logic         clk = 1'b0;
  logic         reset_n;
  logic         m_chipselect, m_read, m_write;
  logic [2:0]   m_address;
  logic [31:0]  m_writedata;
  logic [31:0]  m_readdata;
  logic [65:0]  box_min, box_max;
  logic [307:0] edges;
  logic         frame_valid;
  logic [15:0]  frame_count;
  logic [7:0]   sync_err;
  logic         id_error;

  int unsigned checks = 0;
  int unsigned errors = 0;

  always #5 clk = ~clk;

  msg_frame_reader #(.POLL_GAP(64), .EXPECT_ID(32'h1234EEE2)) dut (
    .clk(clk), .reset_n(reset_n), .m_chipselect(m_chipselect), .m_read(m_read),
    .m_write(m_write), .m_address(m_address), .m_writedata(m_writedata),
    .m_readdata(m_readdata), .box_min(box_min), .box_max(box_max), .edges(edges),
    .frame_valid(frame_valid), .frame_count(frame_count), .sync_err(sync_err),
    .id_error(id_error)
  );

  // Slave contents are written only by the stimulus; pointers/monitors only by the slave.
  logic [31:0] id_val;
  logic [31:0] stat_mem [4];
  int unsigned stat_n;
  logic [31:0] msg_mem [64];
  int unsigned msg_n;

  int unsigned stat_ptr, msg_ptr, cyc, reads, writes, msg_reads, stat_reads;
  int unsigned pulses, b2b, cs_miss, stat_t_prev, stat_t_last, last_msg_cyc, fv_cyc;
  logic        prev_read;
  logic [2:0]  wr_addr;
  logic [31:0] wr_data;

  always @(posedge clk) begin
    if (!reset_n) begin
      stat_ptr <= 0; msg_ptr <= 0; cyc <= 0; reads <= 0; writes <= 0;
      msg_reads <= 0; stat_reads <= 0; pulses <= 0; b2b <= 0; cs_miss <= 0;
      stat_t_prev <= 0; stat_t_last <= 0; last_msg_cyc <= 0; fv_cyc <= 0;
      prev_read <= 1'b0; wr_addr <= '0; wr_data <= '0; m_readdata <= '0;
    end else begin
      cyc       <= cyc + 1;
      prev_read <= m_read;
      if (m_read && prev_read) b2b <= b2b + 1;
      if ((m_read || m_write) && !m_chipselect) cs_miss <= cs_miss + 1;
      if (frame_valid) begin
        pulses <= pulses + 1;
        fv_cyc <= cyc;
      end
      if (m_read) begin
        reads <= reads + 1;
        case (m_address)
          3'd0: begin
            stat_reads  <= stat_reads + 1;
            stat_t_prev <= stat_t_last;
            stat_t_last <= cyc;
            m_readdata  <= (stat_ptr < stat_n) ? stat_mem[stat_ptr] : 32'h0;
            if (stat_ptr < stat_n) stat_ptr <= stat_ptr + 1;
          end
          3'd1: begin
            msg_reads    <= msg_reads + 1;
            last_msg_cyc <= cyc;
            m_readdata   <= (msg_ptr < msg_n) ? msg_mem[msg_ptr] : 32'h0;
            if (msg_ptr < msg_n) msg_ptr <= msg_ptr + 1;
          end
          3'd2:    m_readdata <= id_val;
          default: m_readdata <= 32'hFFFFFFFF;
        endcase
      end
      if (m_write) begin
        writes  <= writes + 1;
        wr_addr <= m_address;
        wr_data <= m_writedata;
      end
    end
  end

  function automatic logic [31:0] hdr_word(input int unsigned h);
    logic [3:0] n;
    if (h == 0) return 32'hAAAAAAAA;
    if (h == 1) return 32'hBBBBBBBB;
    if (h == 2) return 32'hCCCCCCCC;
    n = 4'(h - 2);
    return {8{n}};
  endfunction

  function automatic logic [10:0] minv(input int unsigned s, input int unsigned k);
    return 11'(100 + s*50 + k*3);
  endfunction
  function automatic logic [10:0] maxv(input int unsigned s, input int unsigned k);
    return 11'(200 + s*40 + k*5);
  endfunction
  function automatic logic [10:0] edgev(input int unsigned s, input int unsigned j);
    return 11'(37 + s*20 + j*61);
  endfunction

  function automatic logic [31:0] frame_word(input int unsigned s, input int unsigned i);
    int unsigned d, e;
    if (i % 3 == 0) return hdr_word(i / 3);
    d = (i / 3) * 2 + (i % 3) - 1;
    if (d < 6) return {5'b0, minv(s, d), 5'b0, maxv(s, d)};
    e = d - 6;
    return {5'b0, edgev(s, 2*e), 5'b0, edgev(s, 2*e + 1)};
  endfunction

  function automatic logic [65:0] exp_min(input int unsigned s);
    logic [65:0] v;
    for (int k = 0; k < 6; k++) v[k*11 +: 11] = minv(s, k);
    return v;
  endfunction
  function automatic logic [65:0] exp_max(input int unsigned s);
    logic [65:0] v;
    for (int k = 0; k < 6; k++) v[k*11 +: 11] = maxv(s, k);
    return v;
  endfunction
  function automatic logic [307:0] exp_edges(input int unsigned s);
    logic [307:0] v;
    for (int j = 0; j < 28; j++) v[j*11 +: 11] = edgev(s, j);
    return v;
  endfunction

  task automatic load_frame(input int unsigned off, input int unsigned s);
    for (int i = 0; i < 31; i++) msg_mem[off + i] = frame_word(s, i);
  endtask

  task automatic start_reset();
    reset_n = 1'b0;
    stat_n  = 0;
    msg_n   = 0;
    id_val  = 32'h1234EEE2;
    @(negedge clk);
  endtask

  task automatic end_reset();
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic test_reset();
    start_reset();
    @(negedge clk);
    checks++; if (m_read !== 1'b0 || m_write !== 1'b0 || m_chipselect !== 1'b0) begin
      errors++; $display("FAIL reset_strobes: rd=%b wr=%b cs=%b required 0", m_read, m_write, m_chipselect); end
    checks++; if (box_min !== 66'd0 || box_max !== 66'd0 || edges !== 308'd0) begin
      errors++; $display("FAIL reset_outputs: min=%h max=%h required 0", box_min, box_max); end
    checks++; if (frame_count !== 16'd0 || sync_err !== 8'd0 || id_error !== 1'b0 || frame_valid !== 1'b0) begin
      errors++; $display("FAIL reset_status: fc=%0d se=%0d id=%b fv=%b required 0", frame_count, sync_err, id_error, frame_valid); end
  endtask

  task automatic test_good_frame();
    start_reset();
    stat_mem[0] = 32'd31 << 8; stat_n = 1;
    load_frame(0, 0); msg_n = 31;
    end_reset();
    for (int i = 0; i < 400 && pulses < 1; i++) @(negedge clk);
    repeat (20) @(negedge clk);
    checks++; if (pulses !== 1) begin errors++; $display("FAIL good_pulses: got %0d required 1", pulses); end
    checks++; if (box_min[10:0] !== 11'd100 || box_max[10:0] !== 11'd200 || edges[10:0] !== 11'd37) begin
      errors++; $display("FAIL good_r_edge0: min=%0d max=%0d e0=%0d required 100 200 37", box_min[10:0], box_max[10:0], edges[10:0]); end
    checks++; if (box_min !== exp_min(0) || box_max !== exp_max(0) || edges !== exp_edges(0)) begin
      errors++; $display("FAIL good_full: min=%h required %h edges=%h required %h", box_min, exp_min(0), edges, exp_edges(0)); end
    checks++; if (frame_count !== 16'd1 || sync_err !== 8'd0) begin
      errors++; $display("FAIL good_counts: fc=%0d se=%0d required 1 0", frame_count, sync_err); end
    checks++; if (fv_cyc - last_msg_cyc !== 2 || msg_reads !== 31) begin
      errors++; $display("FAIL good_latency: pulse-read=%0d reads=%0d required 2 31", fv_cyc - last_msg_cyc, msg_reads); end
    checks++; if (b2b !== 0 || cs_miss !== 0) begin
      errors++; $display("FAIL good_bus: b2b=%0d cs_miss=%0d required 0 0", b2b, cs_miss); end
  endtask

  task automatic test_id_error();
    start_reset();
    id_val = 32'hDEADBEEF;
    stat_mem[0] = 32'd31 << 8; stat_n = 1;
    end_reset();
    repeat (200) @(negedge clk);
    checks++; if (id_error !== 1'b1) begin errors++; $display("FAIL id_error: got %b required 1", id_error); end
    checks++; if (reads !== 1 || writes !== 0) begin
      errors++; $display("FAIL id_halt: reads=%0d writes=%0d required 1 0", reads, writes); end
  endtask

  task automatic test_poll_gap();
    start_reset();
    end_reset();
    for (int i = 0; i < 400 && stat_reads < 2; i++) @(negedge clk);
    checks++; if (stat_reads < 2 || stat_t_last - stat_t_prev !== 66) begin
      errors++; $display("FAIL poll_gap: polls=%0d spacing=%0d required 66", stat_reads, stat_t_last - stat_t_prev); end
    checks++; if (msg_reads !== 0) begin errors++; $display("FAIL poll_gap_msg: got %0d required 0", msg_reads); end
  endtask

  task automatic test_bad_header();
    start_reset();
    stat_mem[0] = 32'd31 << 8; stat_mem[1] = 32'd31 << 8; stat_n = 2;
    load_frame(0, 0); load_frame(31, 1);
    msg_mem[34] = 32'hBBBBBBBC; msg_n = 62;
    end_reset();
    for (int i = 0; i < 600 && writes < 1; i++) @(negedge clk);
    repeat (20) @(negedge clk);
    checks++; if (sync_err !== 8'd1) begin errors++; $display("FAIL bad_sync_err: got %0d required 1", sync_err); end
    checks++; if (writes !== 1 || wr_addr !== 3'd0 || wr_data !== 32'h10) begin
      errors++; $display("FAIL bad_flush: writes=%0d addr=%0d data=%h required 1 0 10", writes, wr_addr, wr_data); end
    checks++; if (pulses !== 1 || frame_count !== 16'd1) begin
      errors++; $display("FAIL bad_no_commit: pulses=%0d fc=%0d required 1 1", pulses, frame_count); end
    checks++; if (box_min !== exp_min(0) || box_max !== exp_max(0) || edges !== exp_edges(0)) begin
      errors++; $display("FAIL bad_outputs_held: min=%h required %h", box_min, exp_min(0)); end
    checks++; if (msg_reads !== 35) begin errors++; $display("FAIL bad_stop_reading: got %0d required 35", msg_reads); end
  endtask

  task automatic test_split();
    start_reset();
    stat_mem[0] = 32'd5 << 8; stat_mem[1] = 32'd26 << 8; stat_n = 2;
    load_frame(0, 2); msg_n = 31;
    end_reset();
    for (int i = 0; i < 400 && pulses < 1; i++) @(negedge clk);
    repeat (20) @(negedge clk);
    checks++; if (pulses !== 1 || frame_count !== 16'd1) begin
      errors++; $display("FAIL split_commit: pulses=%0d fc=%0d required 1 1", pulses, frame_count); end
    checks++; if (box_min !== exp_min(2) || box_max !== exp_max(2) || edges !== exp_edges(2)) begin
      errors++; $display("FAIL split_values: min=%h required %h edges=%h required %h", box_min, exp_min(2), edges, exp_edges(2)); end
    checks++; if (b2b !== 0 || stat_reads < 3) begin
      errors++; $display("FAIL split_bus: b2b=%0d polls=%0d required 0 >=3", b2b, stat_reads); end
  endtask

  task automatic test_reset_mid();
    start_reset();
    stat_mem[0] = 32'd31 << 8; stat_n = 1;
    load_frame(0, 1); msg_n = 31;
    end_reset();
    for (int i = 0; i < 300 && msg_reads < 21; i++) @(negedge clk);
    checks++; if (msg_reads !== 21 || pulses !== 0) begin
      errors++; $display("FAIL mid_reach: reads=%0d pulses=%0d required 21 0", msg_reads, pulses); end
    reset_n = 1'b0;
    @(negedge clk);
    checks++; if (m_read !== 1'b0 || m_chipselect !== 1'b0 || frame_count !== 16'd0) begin
      errors++; $display("FAIL mid_drop: rd=%b cs=%b fc=%0d required 0 0 0", m_read, m_chipselect, frame_count); end
    load_frame(0, 2); msg_n = 31;
    end_reset();
    for (int i = 0; i < 400 && pulses < 1; i++) @(negedge clk);
    repeat (20) @(negedge clk);
    checks++; if (pulses !== 1 || frame_count !== 16'd1 || sync_err !== 8'd0) begin
      errors++; $display("FAIL mid_commit: pulses=%0d fc=%0d se=%0d required 1 1 0", pulses, frame_count, sync_err); end
    checks++; if (box_min !== exp_min(2) || box_max !== exp_max(2) || edges !== exp_edges(2)) begin
      errors++; $display("FAIL mid_values: min=%h required %h", box_min, exp_min(2)); end
  endtask

  initial begin
    reset_n = 1'b0;
    stat_n  = 0;
    msg_n   = 0;
    id_val  = 32'h1234EEE2;
    test_reset();
    test_good_frame();
    test_id_error();
    test_poll_gap();
    test_bad_header();
    test_split();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/msg_frame_reader.md
# msg_frame_reader

Avalon-MM master that drains the image processor's message FIFO in hardware and turns its word stream back into structured per-frame results. It checks the processor ID, polls the status register for the buffered word count, reads message words one at a time, and frame-aligns on the header words. Each completed 31-word frame is committed atomically to output registers: six colour x-extents and 28 edge coordinates. It sits between the image-processing slave and the rover navigation logic, replacing software polling on the soft CPU.

## Interface
- POLL_GAP, 64: idle cycles between a status poll that returned zero words and the next poll.
- EXPECT_ID, 32'h1234EEE2: value required from the ID register.
- clk  in  1  system clock.
- reset_n  in  1  synchronous reset, active low.
- m_chipselect  out  1  asserted with every m_read / m_write.
- m_read  out  1  one-cycle read strobe.
- m_write  out  1  one-cycle write strobe.
- m_address  out  3  0 = status, 1 = message, 2 = ID.
- m_writedata  out  32  write data.
- m_readdata  in  32  valid the cycle after m_read.
- box_min  out  66  six 11-bit x_min values, order R, G, B, L, Y, P, with R at [10:0].
- box_max  out  66  six 11-bit x_max values, same order.
- edges  out  308  28 × 11-bit edge coordinates, edge 0 at [10:0].
- frame_valid  out  1  one-cycle pulse when outputs update.
- frame_count  out  16  committed frames, wraps.
- sync_err  out  8  header or format errors, saturates at 255.
- id_error  out  1  sticky; ID mismatch, block halted.

## Operation
- Reset: every output is 0, the FSM is in ID_REQ, and the parser is in HUNT.
- Read transaction:
  - REQ state drives m_chipselect=1, m_read=1 and the address for 1 cycle.
  - WAIT state deasserts them; m_readdata is captured at the end of WAIT.
  - The next REQ is never earlier than the cycle after WAIT. This gives 1 idle cycle between reads, which the slave needs to pop its FIFO correctly.
- FSM:
  - ID_REQ → ID_WAIT. If the captured word equals EXPECT_ID go to POLL_REQ; otherwise go to HALT and set id_error=1.
  - POLL_REQ → POLL_WAIT. Captured bits [15:8] give the word count n. If n > 0, go to MSG_REQ with the remaining count n. If n = 0, go to GAP.
  - GAP counts POLL_GAP cycles, then goes to POLL_REQ.
  - MSG_REQ → MSG_WAIT. Each captured word goes to the parser and the remaining count decrements. While the remaining count is > 0, go to MSG_REQ; at 0, go to POLL_REQ (re-poll; no stale count is ever trusted).
  - FLUSH drives m_write=1, m_address=0, m_writedata=32'h10 for 1 cycle, then goes to POLL_REQ.
  - HALT is terminal until reset.
- Parser, word index i = 0..30:
  - Headers are expected at i = 0, 3, 6, 9, 12, …, 30. Their values in order: AAAAAAAA, BBBBBBBB, CCCCCCCC, 11111111, 22222222, … 88888888.
  - Data words pack [26:16] = first value and [10:0] = second value; bits [31:27] and [15:11] must be 0.
  - Data word order: R, G, B, L, Y, P (min, max pairs), then edge pairs (0,1), (2,3) … (26,27), two pairs between consecutive headers.
  - HUNT discards every word except AAAAAAAA, which sets i=1.
  - A wrong header or nonzero pad bits increments sync_err and returns the parser to HUNT. It also makes the FSM take FLUSH after the current MSG_WAIT instead of continuing.
  - Values are written to shadow registers. On a correct header at i = 30, the shadow registers are copied to the outputs, frame_valid pulses, frame_count increments, and the parser returns to HUNT.
- An AAAAAAAA received mid-frame (i ≠ 0) is a sync error. It flushes, and the next frame is re-acquired from HUNT.

## Timing
- Per word: 2 cycles (REQ, WAIT). A full frame with no polling takes 62 cycles plus one 2-cycle poll.
- frame_valid asserts in the cycle after the MSG_WAIT that captured word 30. Outputs change in that same cycle.
- Outputs stay stable between pulses. A partial or aborted frame never changes them.
- Reset asserted mid-transaction drops all strobes in the next cycle and discards shadow state.
- frame_count wraps from FFFF to 0. sync_err holds at 255.

## Structure
- Package msg_pkg holds:
  - the header constant array (11 × 32 bits) and EXPECT_ID;
  - the register addresses STATUS=0, MSG=1, ID=2 and FLUSH_BIT=4;
  - the FSM state enum.
- Sub-module msg_word_parser holds the index counter, header/pad checks, shadow registers, commit and the sync_err counter. The top level owns the bus FSM only.

## Test plan
- ID slave returns 32'h1234EEE2, status returns 31, then a correct 31-word frame with R=(100,200) and edge0=37 → box_min[10:0]=100, box_max[10:0]=200, edges[10:0]=37, one frame_valid pulse, frame_count=1.
- ID returns 32'hDEADBEEF → id_error=1. No further m_read or m_write ever asserts.
- Status returns 0 → next m_read to address 0 occurs exactly POLL_GAP+1 cycles after POLL_WAIT.
- Word 3 = 32'hBBBBBBBC → sync_err=1, one FLUSH write of 32'h10 to address 0, outputs unchanged, no frame_valid.
- Frame arrives split across polls with counts 5 then 26 → single commit, identical to the contiguous case. m_read is never asserted in two consecutive cycles.
- reset_n low during MSG_WAIT at i=20, then a full frame → only the post-reset frame commits, frame_count=1.
